wb_commit_unit: RTL



---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 51 +++++
 rtl/wb_commit_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback commit unit.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned RF_ADDR_W  = 4;
  localparam int unsigned SB_CNT_W   = 2;
  localparam int unsigned WB_DATA_W  = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous in-order FIFO with occupancy count and full/empty flags.
module wb_fifo #(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr];
  assign o_count   = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Merges ALU/memory writebacks into the single RF write port and tracks pending writes.
// Optional WB_BYPASS_EN: an accepted request skips the empty queue and commits one cycle sooner.
module wb_commit_unit
  import wb_pkg::*;
#(
  parameter int unsigned  REG_SIZE   = WB_DATA_W,  // must match wb_req_t data width
  parameter int unsigned  REG_NUMBER = 8,
  parameter int unsigned  FIFO_DEPTH = 4,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [REG_ADDR_W-1:0] i_alu_addr,
  input  logic [REG_SIZE-1:0]   i_alu_data,
  input  logic                  i_mem_valid,
  output logic                  o_mem_ready,
  input  logic [REG_ADDR_W-1:0] i_mem_addr,
  input  logic [REG_SIZE-1:0]   i_mem_data,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_addr,
  output logic [REG_NUMBER-1:0] o_busy_vec,
  output logic                  o_rf_we,
  output logic [RF_ADDR_W-1:0]  o_rf_waddr,
  output logic [REG_SIZE-1:0]   o_rf_wdata,
  output logic [CNT_W-1:0]      o_fifo_count,
  output logic                  o_sb_err
);

  wb_req_t               w_req;
  wb_req_t               w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_acc;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [REG_SIZE-1:0]   r_data;

  // Memory has fixed priority; readiness comes from the registered count only.
  assign o_mem_ready = !w_full;
  assign o_alu_ready = !w_full && !i_mem_valid;
  assign w_acc       = (i_mem_valid && o_mem_ready) || (i_alu_valid && o_alu_ready);
  assign w_pop       = !w_empty;

  always_comb begin
    if (i_mem_valid) begin
      w_req.addr = i_mem_addr;
      w_req.data = i_mem_data;
    end else begin
      w_req.addr = i_alu_addr;
      w_req.data = i_alu_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign w_bypass = w_acc && w_empty;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_push = w_acc && !w_bypass;

  wb_fifo #(
    .WIDTH ($bits(wb_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_req),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (o_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_bypass) begin
      r_we   <= 1'b1;
      r_addr <= w_req.addr;
      r_data <= w_req.data;
    end else if (w_pop) begin
      r_we   <= 1'b1;
      r_addr <= w_head.addr;
      r_data <= w_head.data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign o_rf_we    = r_we;
  assign o_rf_waddr = {1'b0, r_addr};
  assign o_rf_wdata = r_data;

  logic [SB_CNT_W-1:0]   r_sb_cnt   [REG_NUMBER];
  logic [SB_CNT_W-1:0]   w_sb_cnt_d [REG_NUMBER];
  logic [REG_NUMBER-1:0] w_inc;
  logic [REG_NUMBER-1:0] w_dec;
  logic                  r_sb_err;
  logic                  w_sb_err_d;

  always_comb begin
    for (int i = 0; i < REG_NUMBER; i++) begin
      w_inc[i] = i_issue_valid && (i_issue_addr == REG_ADDR_W'(i));
      w_dec[i] = r_we && (r_addr == REG_ADDR_W'(i));
    end
  end

  // Simultaneous issue and commit on one register cancel out.
  always_comb begin
    w_sb_err_d = r_sb_err;
    for (int i = 0; i < REG_NUMBER; i++) begin
      w_sb_cnt_d[i] = r_sb_cnt[i];
      o_busy_vec[i] = (r_sb_cnt[i] != '0);
      if (w_inc[i] && !w_dec[i]) begin
        if (r_sb_cnt[i] == '1) w_sb_err_d = 1'b1;
        else                   w_sb_cnt_d[i] = r_sb_cnt[i] + 1'b1;
      end else if (w_dec[i] && !w_inc[i]) begin
        if (r_sb_cnt[i] == '0) w_sb_err_d = 1'b1;
        else                   w_sb_cnt_d[i] = r_sb_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_err <= 1'b0;
      for (int i = 0; i < REG_NUMBER; i++) r_sb_cnt[i] <= '0;
    end else begin
      r_sb_err <= w_sb_err_d;
      r_sb_cnt <= w_sb_cnt_d;
    end
  end

  assign o_sb_err = r_sb_err;

endmodule
